// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, value limits, FSM encoding and the
// saturation helpers used by every ALU stage.
package alu_pkg;

  localparam int W    = 11;
  localparam int WIDE = 2 * W;
  localparam int VMAX = 999;
  localparam int VMIN = -999;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_NEG = 3'd5;
  localparam logic [2:0] OP_SAV = 3'd6;
  localparam logic [2:0] OP_SWP = 3'd7;

  typedef enum logic {
    IDLE   = 1'b0,
    MUL_EX = 1'b1
  } state_t;

  // Values are carried at double width so any sum or product of two
  // in-range operands is exact before clamping.
  function automatic logic over(input logic signed [WIDE-1:0] v,
                                input logic signed [WIDE-1:0] lim);
    return (v > lim) || (v < -lim);
  endfunction

  function automatic logic signed [W-1:0] clamp(input logic signed [WIDE-1:0] v,
                                                input logic signed [WIDE-1:0] lim);
    logic signed [WIDE-1:0] nlim;
    nlim = -lim;
    if (v > lim) return lim[W-1:0];
    else if (v < nlim) return nlim[W-1:0];
    else return v[W-1:0];
  endfunction

endpackage

// File: rtl/mul.sv
// Combinational saturating multiplier: out = clamp(acc * arg1) to +-VMAX,
// ovf flags that the exact product fell outside that range.
module mul #(
  parameter int W    = alu_pkg::W,
  parameter int VMAX = alu_pkg::VMAX
) (
  input  logic signed [W-1:0] acc,
  input  logic signed [W-1:0] arg1,
  output logic signed [W-1:0] out,
  output logic                ovf
);
  import alu_pkg::*;

  localparam int XW = 2 * W;
  localparam logic signed [XW-1:0] LIM = XW'(VMAX);

  logic signed [XW-1:0] prod;

  // Sign-extended operands; the low XW bits of the product are exact.
  assign prod = {{W{acc[W-1]}}, acc} * {{W{arg1[W-1]}}, arg1};
  assign out  = clamp(prod, LIM);
  assign ovf  = over(prod, LIM);

endmodule

// File: rtl/alu_acc.sv
// ALU accumulator stage: ACC/BAK registers, one op per valid/ready handshake.
// Non-MUL ops complete on the accept edge; MUL takes one extra cycle in MUL_EX.
module alu_acc #(
  parameter int W    = alu_pkg::W,
  parameter int VMAX = alu_pkg::VMAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op_code,
  input  logic [W-1:0] op_arg,
  output logic [W-1:0] acc,
  output logic [W-1:0] bak,
  output logic         acc_zero,
  output logic         acc_neg,
  output logic         done,
  output logic         sat
);
  import alu_pkg::*;

  localparam int XW = 2 * W;
  localparam logic signed [XW-1:0] LIM = XW'(VMAX);

  state_t state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d, bak_q, bak_d;
  logic signed [W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic done_q, done_d, sat_q, sat_d;

  logic                 accept;
  logic signed [W-1:0]  arg_c, mul_out;
  logic                 mul_ovf;
  logic signed [XW-1:0] acc_x, arg_x, sum_x, dif_x;

  assign op_ready = (state_q == IDLE) && !rst;
  assign accept   = op_valid && op_ready;

  // Operand clamp is silent: it never raises sat on its own.
  assign arg_c = clamp({{W{op_arg[W-1]}}, op_arg}, LIM);
  assign acc_x = {{W{acc_q[W-1]}}, acc_q};
  assign arg_x = {{W{arg_c[W-1]}}, arg_c};
  assign sum_x = acc_x + arg_x;
  assign dif_x = acc_x - arg_x;

  mul #(.W(W), .VMAX(VMAX)) u_mul (
    .acc  (opa_q),
    .arg1 (opb_q),
    .out  (mul_out),
    .ovf  (mul_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bak_d   = bak_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          sat_d  = 1'b0;
          unique case (op_code)
            OP_NOP: ;
            OP_MOV: acc_d = arg_c;
            OP_ADD: begin
              acc_d = clamp(sum_x, LIM);
              sat_d = over(sum_x, LIM);
            end
            OP_SUB: begin
              acc_d = clamp(dif_x, LIM);
              sat_d = over(dif_x, LIM);
            end
            OP_MUL: begin
              // Result and flag arrive from MUL_EX; sat holds until then.
              opa_d   = acc_q;
              opb_d   = arg_c;
              sat_d   = sat_q;
              done_d  = 1'b0;
              state_d = MUL_EX;
            end
            OP_NEG: acc_d = -acc_q;
            OP_SAV: bak_d = acc_q;
            OP_SWP: begin
              acc_d = bak_q;
              bak_d = acc_q;
            end
          endcase
        end
      end
      MUL_EX: begin
        acc_d   = mul_out;
        sat_d   = mul_ovf;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      bak_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bak_q   <= bak_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  assign acc      = acc_q;
  assign bak      = bak_q;
  assign acc_zero = (acc_q == '0);
  assign acc_neg  = acc_q[W-1];
  assign done     = done_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_alu_acc.sv
// Bench for alu_acc: integer reference model checked every cycle, plus
// directed sequences with hand-computed literal expectations.
module tb_alu_acc;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_valid = 1'b0;
  logic [2:0]   op_code = 3'd0;
  logic [W-1:0] op_arg = '0;
  logic         op_ready;
  logic [W-1:0] acc, bak;
  logic         acc_zero, acc_neg, done, sat;

  alu_acc #(.W(W), .VMAX(999)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .op_arg   (op_arg),
    .acc      (acc),
    .bak      (bak),
    .acc_zero (acc_zero),
    .acc_neg  (acc_neg),
    .done     (done),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_done = 0;
  int cyc = 0;

  int m_acc = 0, m_bak = 0, m_opa = 0, m_opb = 0;
  bit m_sat = 0, m_done = 0, m_pend = 0, m_live = 0;

  function automatic int lim999(input int v);
    if (v > 999) return 999;
    if (v < -999) return -999;
    return v;
  endfunction

  function automatic bit out999(input int v);
    return (v > 999) || (v < -999);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural effect of each op on integers.
  always @(posedge clk) begin : model
    int a, v;
    cyc++;
    m_done = 0;
    if (rst) begin
      m_acc = 0; m_bak = 0; m_sat = 0; m_pend = 0;
    end else if (m_pend) begin
      v      = m_opa * m_opb;
      m_sat  = out999(v);
      m_acc  = lim999(v);
      m_pend = 0;
      m_done = 1;
    end else if (op_valid) begin
      a      = lim999($signed(op_arg));
      m_done = 1;
      m_sat  = 0;
      case (op_code)
        3'd1: m_acc = a;
        3'd2: begin v = m_acc + a; m_sat = out999(v); m_acc = lim999(v); end
        3'd3: begin v = m_acc - a; m_sat = out999(v); m_acc = lim999(v); end
        3'd4: begin
          m_opa = m_acc; m_opb = a; m_pend = 1; m_done = 0;
          m_sat = sat;
        end
        3'd5: m_acc = -m_acc;
        3'd6: m_bak = m_acc;
        3'd7: begin v = m_acc; m_acc = m_bak; m_bak = v; end
        default: ;
      endcase
    end
    m_live = 1;
  end

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (m_live) begin
      chk("acc", $signed(acc), m_acc);
      chk("bak", $signed(bak), m_bak);
      chk("sat", int'(sat), int'(m_sat));
      chk("done", int'(done), int'(m_done));
      chk("acc_zero", int'(acc_zero), int'(m_acc == 0));
      chk("acc_neg", int'(acc_neg), int'(m_acc < 0));
      chk("op_ready", int'(op_ready), int'(!m_pend && !rst));
    end
  end

  task automatic do_op(input int c, input int a);
    bit took;
    op_valid = 1'b1;
    op_code  = c[2:0];
    op_arg   = a[W-1:0];
    took     = 0;
    for (int i = 0; i < 8 && !took; i++) begin
      took = !m_pend && !rst;
      @(posedge clk);
      #2;
    end
    op_valid = 1'b0;
    if (!took) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n0, c0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_acc", $signed(acc), 0);
    chk("rst_bak", $signed(bak), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_ready", int'(op_ready), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", int'(op_ready), 1);

    do_op(1, 500);
    chk("mov500", $signed(acc), 500);
    chk("mov500_done", int'(done), 1);
    do_op(2, 600);
    chk("add_sat_acc", $signed(acc), 999);
    chk("add_sat_flag", int'(sat), 1);
    chk("add_done", int'(done), 1);
    chk("add_neg", int'(acc_neg), 0);
    idle(1);
    chk("done_one_cycle", int'(done), 0);
    chk("sat_holds", int'(sat), 1);

    do_op(1, -700);
    do_op(3, 400);
    chk("sub_sat_acc", $signed(acc), -999);
    chk("sub_sat_flag", int'(sat), 1);
    chk("sub_neg", int'(acc_neg), 1);
    do_op(5, 0);
    chk("neg_acc", $signed(acc), 999);
    chk("neg_sat", int'(sat), 0);

    do_op(1, 30);
    do_op(4, 33);
    chk("mul_busy", int'(op_ready), 0);
    chk("mul_acc_hold", $signed(acc), 30);
    idle(1);
    chk("mul_acc", $signed(acc), 990);
    chk("mul_done", int'(done), 1);
    chk("mul_sat", int'(sat), 0);
    chk("mul_ready_back", int'(op_ready), 1);
    do_op(4, -2);
    idle(1);
    chk("mul_neg_sat_acc", $signed(acc), -999);
    chk("mul_neg_sat_flag", int'(sat), 1);
    idle(1);

    n0 = n_done;
    c0 = cyc;
    do_op(1, 12);
    do_op(6, 0);
    do_op(1, -5);
    do_op(7, 0);
    chk("b2b_cycles", cyc - c0, 4);
    chk("swp_acc", $signed(acc), 12);
    chk("swp_bak", $signed(bak), -5);
    idle(1);
    chk("b2b_done_pulses", n_done - n0, 4);

    do_op(1, 1023);
    chk("mov_clamp_acc", $signed(acc), 999);
    chk("mov_clamp_sat", int'(sat), 0);
    do_op(1, 0);
    chk("acc_zero", int'(acc_zero), 1);

    do_op(1, 100);
    do_op(4, 7);
    rst = 1'b1;
    idle(1);
    chk("abort_acc", $signed(acc), 0);
    chk("abort_bak", $signed(bak), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready_in_rst", int'(op_ready), 0);
    rst = 1'b0;
    #1;
    chk("abort_ready", int'(op_ready), 1);
    n0 = n_done;
    idle(3);
    chk("abort_no_write", $signed(acc), 0);
    chk("abort_no_done", n_done - n0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
